ram_nr2w_lvt: RTL
=================

RAM_NR2W_LVT -- requirements
Module: ram_nr2w_lvt

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 11, address width in bits; depth = 2^ADDR_W words.
REQ-003 SHALL have parameter NUM_R, default 8, number of read ports (1..32).
REQ-004 SHALL have parameter BYPASS, default 1, read-during-write mode: 1 = new data, 0 = old data.
REQ-005 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports w_enb_1 / w_enb_2, input, 1 each, write enables for write ports 1 and 2.
REQ-008 SHALL have ports w_addr_1 / w_addr_2, input, ADDR_W each, write addresses.
REQ-009 SHALL have ports w_din_1 / w_din_2, input, DATA_W each, write data.
REQ-010 SHALL have port r_addr, input, NUM_R*ADDR_W, packed read addresses; port k at [k*ADDR_W +: ADDR_W].
REQ-011 SHALL have port r_dout, output, NUM_R*DATA_W, packed registered read data; port k at [k*DATA_W +: DATA_W].
REQ-012 SHALL have port w_conflict, output, 1, registered flag for a same-address double write.

Function
REQ-013 SHALL implement storage by replication: two bank groups (one per write port), each with NUM_R 1W1R replicas.
REQ-014 SHALL update all NUM_R replicas of group g on every accepted write from port g.
REQ-015 SHALL keep a Live Value Table (LVT) of 2^ADDR_W x 1 bit; on an accepted write it records the writing group for that address.
REQ-016 SHALL accept a write from port g at a rising edge when rst=1 and w_enb_g=1.
REQ-017 SHALL, when both ports write the same address in one cycle, give port 2 priority: suppress port 1's write and set LVT to group 2.
REQ-018 SHALL set w_conflict=1 in the cycle after a REQ-017 event and clear it in every other cycle.
REQ-019 SHALL, for every read port k, sample r_addr[k] at edge t and present the addressed word on r_dout[k] after edge t+1 (latency 1); r_dout holds between updates.
REQ-020 SHALL select the group for each read from the LVT entry sampled at the same edge as the address.
REQ-021 SHALL, with BYPASS=1, return the data written at edge t when r_addr[k] equals an accepted write address at edge t; a port-2 match takes precedence over a port-1 match.
REQ-022 SHALL, with BYPASS=0, return the pre-write contents in the REQ-021 case.
REQ-023 SHALL let distinct-address writes from both ports and all NUM_R reads proceed in the same cycle without stalls.
REQ-024 SHALL wrap no addresses; every ADDR_W-bit value, including 0 and 2^ADDR_W-1, is a valid location.

Reset
REQ-025 SHALL, on rst=0 and asynchronously, force all r_dout to 0, w_conflict to 0, and all LVT entries to group 1.
REQ-026 SHALL ignore writes while rst=0; bank contents are not reset, and data written before reset is undefined afterwards.
REQ-027 SHALL resume normal operation at the first rising edge with rst=1.

Verification
REQ-028 Reset: rst=0 with random inputs -> every r_dout=0 and w_conflict=0 immediately, before any clock edge.
REQ-029 Broadcast read: port 1 writes 0x005=0xDEADBEEF; next cycle all 8 ports read 0x005 -> all r_dout=0xDEADBEEF one cycle later.
REQ-030 Conflict: same cycle, port 1 writes 0x010=0x11111111 and port 2 writes 0x010=0x22222222 -> w_conflict=1 for exactly one cycle; a later read of 0x010 returns 0x22222222.
REQ-031 LVT ordering: port 2 writes 0x7FF=0xA5A5A5A5, next cycle port 1 writes 0x7FF=0x5A5A5A5A -> a read of 0x7FF returns 0x5A5A5A5A; a read of 0x000 after 0x000=0x1 (port 2) returns 0x1.
REQ-032 Read-during-write: 0x020 holds 0x1; port 1 writes 0x2 while port 0 reads 0x020 in the same cycle -> r_dout[0]=0x2 if BYPASS=1, 0x1 if BYPASS=0.
REQ-033 Mid-operation reset: drop rst between edges with w_enb_1=1 -> r_dout=0 at once and no write during rst=0; after release, port 1 writes 0x040=0x7 -> a read of 0x040 returns 0x7.

Source files
------------

// File: rtl/ram_nr2w_lvt_if.sv
// Bus bundle for the 2-write / N-read LVT RAM: both write ports, packed read
// addresses, packed read data and the double-write flag.
interface ram_nr2w_lvt_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11,
  parameter int NUM_R  = 8
);
  logic                      w_enb_1;
  logic                      w_enb_2;
  logic [ADDR_W-1:0]         w_addr_1;
  logic [ADDR_W-1:0]         w_addr_2;
  logic [DATA_W-1:0]         w_din_1;
  logic [DATA_W-1:0]         w_din_2;
  logic [NUM_R*ADDR_W-1:0]   r_addr;
  logic [NUM_R*DATA_W-1:0]   r_dout;
  logic                      w_conflict;

  modport master (
    output w_enb_1, w_enb_2, w_addr_1, w_addr_2, w_din_1, w_din_2, r_addr,
    input  r_dout, w_conflict
  );

  modport slave (
    input  w_enb_1, w_enb_2, w_addr_1, w_addr_2, w_din_1, w_din_2, r_addr,
    output r_dout, w_conflict
  );
endinterface

// File: rtl/ram_nr2w_lvt.sv
// 2-write / NUM_R-read RAM built from replicated 1W1R banks (one group per write
// port); a 1-bit live value table records which group holds each address's word.
module ram_nr2w_lvt #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11,
  parameter int NUM_R  = 8,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst,
  ram_nr2w_lvt_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic                    same_addr_s;
  logic                    conflict_s;
  logic                    wr1_s;
  logic                    wr2_s;
  logic [DEPTH-1:0]        lvt_r;
  logic                    w_conflict_r;
  logic [NUM_R*DATA_W-1:0] r_dout_s;

  // Port 2 wins a same-address double write, so port 1 is dropped in that case.
  assign same_addr_s = (bus.w_addr_1 == bus.w_addr_2);
  assign wr2_s       = rst & bus.w_enb_2;
  assign wr1_s       = rst & bus.w_enb_1 & ~(bus.w_enb_2 & same_addr_s);
  assign conflict_s  = rst & bus.w_enb_1 & bus.w_enb_2 & same_addr_s;

  // Live value table: 0 = group 1 holds the current word, 1 = group 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvt_r <= {DEPTH{1'b0}};
    end else begin
      if (wr1_s) lvt_r[bus.w_addr_1] <= 1'b0;
      if (wr2_s) lvt_r[bus.w_addr_2] <= 1'b1;
    end
  end

  // Double-write flag, high for the single cycle after the event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) w_conflict_r <= 1'b0;
    else      w_conflict_r <= conflict_s;
  end

  for (genvar k = 0; k < NUM_R; k++) begin : g_rd
    logic [ADDR_W-1:0] ra_s;
    logic [DATA_W-1:0] bank1_r [DEPTH];
    logic [DATA_W-1:0] bank2_r [DEPTH];
    logic [DATA_W-1:0] rd_s;
    logic [DATA_W-1:0] stage_r;
    logic [DATA_W-1:0] dout_r;

    assign ra_s = bus.r_addr[k*ADDR_W +: ADDR_W];

    // Replica k of each group mirrors every accepted write of that group.
    always_ff @(posedge clk) begin
      if (wr1_s) bank1_r[bus.w_addr_1] <= bus.w_din_1;
      if (wr2_s) bank2_r[bus.w_addr_2] <= bus.w_din_2;
    end

    // Same-edge writes are forwarded (port 2 first) only in new-data mode.
    always_comb begin
      rd_s = {DATA_W{1'b0}};
      if ((BYPASS != 32'sd0) && wr2_s && (ra_s == bus.w_addr_2)) begin
        rd_s = bus.w_din_2;
      end else if ((BYPASS != 32'sd0) && wr1_s && (ra_s == bus.w_addr_1)) begin
        rd_s = bus.w_din_1;
      end else if (lvt_r[ra_s]) begin
        rd_s = bank2_r[ra_s];
      end else begin
        rd_s = bank1_r[ra_s];
      end
    end

    // Word resolved at the sampling edge, presented on r_dout one edge later.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        stage_r <= {DATA_W{1'b0}};
        dout_r  <= {DATA_W{1'b0}};
      end else begin
        stage_r <= rd_s;
        dout_r  <= stage_r;
      end
    end

    assign r_dout_s[k*DATA_W +: DATA_W] = dout_r;
  end

  assign bus.r_dout     = r_dout_s;
  assign bus.w_conflict = w_conflict_r;
endmodule
